// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: RV32M sequencer for the iterative MCycle mul/div unit.
// Resolves divide special cases and caches the last divide result.
module mcycle_ctrl #(
  parameter int WIDTH    = 32,
  parameter bit REUSE_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_op1,
  input  logic [WIDTH-1:0] req_op2,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy,
  output logic             mc_reset,
  output logic             mc_start,
  output logic [1:0]       mc_op,
  output logic [WIDTH-1:0] mc_operand1,
  output logic [WIDTH-1:0] mc_operand2,
  input  logic [WIDTH-1:0] mc_result1,
  input  logic [WIDTH-1:0] mc_result2,
  input  logic             mc_busy
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RESP, DRAIN
  } state_t;

  localparam logic [WIDTH-1:0] SMIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [2:0]       f3_q;
  logic             hsu_q;
  logic             c_valid, c_sgn;
  logic [WIDTH-1:0] c_op1, c_op2;
  logic [WIDTH-1:0] c_quo, c_rem;

  logic             accept, done;
  logic             rq_div, rq_rem, rq_sgn;
  logic             rq_dz, rq_ovf, rq_hit;
  logic             rq_fast;
  logic [1:0]       rq_op;
  logic [WIDTH-1:0] fast_data;
  logic             sel_hi;
  logic [WIDTH-1:0] raw, corr, wait_data;

  assign req_ready  = (state_q == IDLE)
                    & RESET & ~flush;
  assign accept     = req_valid & req_ready;
  assign busy       = (state_q != IDLE);
  assign mc_start   = (state_q == ISSUE);
  assign resp_valid = (state_q == RESP) & ~flush;
  assign mc_reset   = ~RESET;

  assign rq_div = req_funct3[2];
  assign rq_rem = req_funct3[1];
  assign rq_sgn = ~req_funct3[0];
  assign rq_dz  = rq_div & (req_op2 == '0);
  assign rq_ovf = rq_div & rq_sgn
                & (req_op1 == SMIN)
                & (req_op2 == '1);
  assign rq_hit = REUSE_EN & rq_div & c_valid
                & (c_op1 == req_op1)
                & (c_op2 == req_op2)
                & (c_sgn == rq_sgn);
  assign rq_fast = rq_dz | rq_ovf | rq_hit;

  assign rq_op = rq_div
    ? {1'b1, req_funct3[0]}
    : {1'b0, req_funct3 != 3'b001};

  always_comb begin
    fast_data = '0;
    unique case (1'b1)
      rq_dz:   fast_data = rq_rem ? req_op1 : '1;
      rq_ovf:  fast_data = rq_rem ? '0 : SMIN;
      default: fast_data = rq_rem ? c_rem : c_quo;
    endcase
  end

  // MULHSU runs unsigned; subtract op2 when rs1 is negative
  assign sel_hi = f3_q[2] ? f3_q[1]
                          : (f3_q[1:0] != 2'b00);
  assign raw  = sel_hi ? mc_result2 : mc_result1;
  assign corr = (f3_q == 3'b010 && hsu_q)
              ? mc_operand2 : '0;
  assign wait_data = raw - corr;

  assign done = (state_q == WAIT)
              & ~mc_busy & ~flush;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept)
          state_d = rq_fast ? RESP : ISSUE;
      ISSUE:
        state_d = flush ? DRAIN : WAIT;
      WAIT:
        if (flush)         state_d = DRAIN;
        else if (!mc_busy) state_d = RESP;
      RESP:
        state_d = IDLE;
      DRAIN:
        if (!mc_busy) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      f3_q        <= '0;
      hsu_q       <= 1'b0;
      mc_op       <= '0;
      mc_operand1 <= '0;
      mc_operand2 <= '0;
      resp_data   <= '0;
      c_valid     <= 1'b0;
      c_sgn       <= 1'b0;
      c_op1       <= '0;
      c_op2       <= '0;
      c_quo       <= '0;
      c_rem       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        f3_q        <= req_funct3;
        hsu_q       <= req_op1[WIDTH-1];
        mc_op       <= rq_op;
        mc_operand1 <= req_op1;
        mc_operand2 <= req_op2;
        if (rq_fast)
          resp_data <= fast_data;
      end
      if (done) begin
        resp_data <= wait_data;
        if (REUSE_EN && f3_q[2]) begin
          c_valid <= 1'b1;
          c_sgn   <= ~f3_q[0];
          c_op1   <= mc_operand1;
          c_op2   <= mc_operand2;
          c_quo   <= mc_result1;
          c_rem   <= mc_result2;
        end
      end
    end
  end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb_mcycle_ctrl: directed bench with a behavioural MCycle unit.
// Checks results, latency, start pulses, cache, flush and reset.
module tb_mcycle_ctrl;

  localparam int LAT = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_op1 = '0;
  logic [31:0] req_op2 = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        busy, mc_reset, mc_start;
  logic [1:0]  mc_op;
  logic [31:0] mc_operand1, mc_operand2;
  logic [31:0] mr1 = '0, mr2 = '0;
  logic        mb = 1'b0;
  int          cnt = 0;
  int          restart_err = 0;

  int n_tests = 0;
  int n_fail  = 0;

  mcycle_ctrl #(.WIDTH(32), .REUSE_EN(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3),
    .req_op1(req_op1), .req_op2(req_op2),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .busy(busy), .mc_reset(mc_reset),
    .mc_start(mc_start), .mc_op(mc_op),
    .mc_operand1(mc_operand1),
    .mc_operand2(mc_operand2),
    .mc_result1(mr1), .mc_result2(mr2),
    .mc_busy(mb)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] unit_calc(
    input logic [1:0] op,
    input logic [31:0] a, b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    unique case (op)
      2'b00: unit_calc = 64'(sa * sb);
      2'b01: unit_calc = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) unit_calc = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          unit_calc = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) unit_calc = {a, 32'hFFFFFFFF};
        else unit_calc = {a % b, a / b};
      end
    endcase
  endfunction

  // Behavioural MCycle: busy for LAT cycles after a Start edge
  always @(posedge CLK) begin
    if (mc_reset) begin
      mb  <= 1'b0;
      cnt <= 0;
    end else if (mc_start && !mb) begin
      mb  <= 1'b1;
      cnt <= LAT;
      {mr2, mr1} <= unit_calc(mc_op,
                              mc_operand1,
                              mc_operand2);
    end else if (mb) begin
      if (mc_start) restart_err <= restart_err + 1;
      cnt <= cnt - 1;
      if (cnt == 1) mb <= 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic run_req(
    input  logic [2:0]  f3,
    input  logic [31:0] a, b,
    output int          lat,
    output bit          st,
    output logic [1:0]  op,
    output logic [31:0] d);
    lat = 0; st = 1'b0; op = '0; d = '0;
    @(negedge CLK);
    req_funct3 = f3;
    req_op1 = a;
    req_op2 = b;
    req_valid = 1'b1;
    chk("req_ready", 32'(req_ready), 1);
    @(negedge CLK);
    req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (mc_start) begin
        st = 1'b1;
        op = mc_op;
      end
      if (resp_valid) begin
        lat = k;
        d = resp_data;
        break;
      end
      @(negedge CLK);
    end
    if (lat == 0) chk("resp_timeout", 0, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rv"}, 32'(resp_valid), 0);
    chk({tag, "_rd"}, resp_data, 0);
    chk({tag, "_st"}, 32'(mc_start), 0);
    chk({tag, "_op"}, 32'(mc_op), 0);
    chk({tag, "_o1"}, mc_operand1, 0);
    chk({tag, "_o2"}, mc_operand2, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rdy"}, 32'(req_ready), 0);
    chk({tag, "_mcr"}, 32'(mc_reset), 1);
  endtask

  initial begin
    int          lat;
    bit          st;
    logic [1:0]  op;
    logic [31:0] d;
    bit          seen;
    int          hold_err;

    repeat (3) @(negedge CLK);
    chk_reset("rst0");
    RESET = 1'b1;

    run_req(3'b000, 32'd7, 32'hFFFFFFFD,
            lat, st, op, d);
    chk("mul_data", d, 32'hFFFFFFEB);
    chk("mul_op", 32'(op), 32'h1);
    chk("mul_lat", 32'(lat), LAT + 3);

    run_req(3'b001, 32'd7, 32'hFFFFFFFD,
            lat, st, op, d);
    chk("mulh_data", d, 32'hFFFFFFFF);
    chk("mulh_op", 32'(op), 32'h0);

    run_req(3'b010, 32'hFFFFFFFF, 32'd2,
            lat, st, op, d);
    chk("mulhsu_data", d, 32'hFFFFFFFF);
    chk("mulhsu_op", 32'(op), 32'h1);

    run_req(3'b101, 32'd5, 32'd0,
            lat, st, op, d);
    chk("divu0_data", d, 32'hFFFFFFFF);
    chk("divu0_lat", 32'(lat), 1);
    chk("divu0_start", 32'(st), 0);

    run_req(3'b110, 32'd9, 32'd0,
            lat, st, op, d);
    chk("rem0_data", d, 32'd9);

    run_req(3'b100, 32'h80000000, 32'hFFFFFFFF,
            lat, st, op, d);
    chk("ovf_div", d, 32'h80000000);
    chk("ovf_div_start", 32'(st), 0);

    run_req(3'b110, 32'h80000000, 32'hFFFFFFFF,
            lat, st, op, d);
    chk("ovf_rem", d, 32'h0);

    run_req(3'b100, 32'd100, 32'd7,
            lat, st, op, d);
    chk("div_data", d, 32'd14);
    chk("div_start", 32'(st), 1);
    chk("div_op", 32'(op), 32'h2);

    run_req(3'b110, 32'd100, 32'd7,
            lat, st, op, d);
    chk("hit_data", d, 32'd2);
    chk("hit_lat", 32'(lat), 1);
    chk("hit_start", 32'(st), 0);

    run_req(3'b111, 32'd100, 32'd7,
            lat, st, op, d);
    chk("remu_data", d, 32'd2);
    chk("remu_start", 32'(st), 1);
    chk("remu_op", 32'(op), 32'h3);

    // flush in the second WAIT cycle
    @(negedge CLK);
    req_funct3 = 3'b100;
    req_op1 = 32'd200;
    req_op2 = 32'd9;
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("fl_mcbusy", 32'(mb), 1);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    seen = 1'b0;
    hold_err = 0;
    for (int k = 0; k < 12; k++) begin
      if (resp_valid) seen = 1'b1;
      if (mb && !busy) hold_err++;
      @(negedge CLK);
    end
    chk("fl_no_resp", 32'(seen), 0);
    chk("fl_busy_hold", 32'(hold_err), 0);
    chk("fl_idle", 32'(busy), 0);

    run_req(3'b100, 32'd200, 32'd9,
            lat, st, op, d);
    chk("fl_miss_start", 32'(st), 1);
    chk("fl_miss_data", d, 32'd22);

    // reset in WAIT
    @(negedge CLK);
    req_funct3 = 3'b101;
    req_op1 = 32'd1000;
    req_op2 = 32'd3;
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    chk("rw_busy", 32'(busy), 1);
    RESET = 1'b0;
    @(negedge CLK);
    chk_reset("rst1");
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    run_req(3'b000, 32'd3, 32'd5,
            lat, st, op, d);
    chk("mul35", d, 32'd15);

    run_req(3'b100, 32'd200, 32'd9,
            lat, st, op, d);
    chk("rst_cache_start", 32'(st), 1);
    chk("rst_cache_data", d, 32'd22);

    chk("restart", 32'(restart_err), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mcycle_ctrl.md
# mcycle_ctrl

Sequencer for the iterative multiply/divide unit (MCycle). It accepts one RV32M request at a time from the EX stage. It decodes funct3 into an MCycle operation, drives the unit's Start/Busy handshake and selects the result half. It resolves the RISC-V special cases (divide-by-zero, signed overflow, MULHSU) and answers a DIV/REM pair on identical operands from a one-entry result cache, so those cases never launch the unit.

## Interface
- WIDTH, 32, operand/result width; MCycle's byte-sliced multiplier fixes this at 32.
- REUSE_EN, 1, enables the one-entry divide result cache.

- CLK  in  1  clock
- RESET  in  1  synchronous, active-low reset
- flush  in  1  pipeline flush; kills the in-flight request
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_funct3  in  3  RV32M funct3 (000 MUL … 111 REMU)
- req_op1, req_op2  in  WIDTH  rs1 / rs2 values
- resp_valid  out  1  one-cycle pulse, resp_data valid
- resp_data  out  WIDTH  instruction result
- busy  out  1  stall to pipeline: state != IDLE
- mc_reset  out  1  = ~RESET (MCycle reset is active-high)
- mc_start  out  1  one-cycle Start pulse
- mc_op  out  2  MCycleOp: 00 mul s, 01 mul u, 10 div s, 11 div u
- mc_operand1, mc_operand2  out  WIDTH  registered operands
- mc_result1, mc_result2  in  WIDTH  LSW/quotient, MSW/remainder
- mc_busy  in  1  MCycle Busy

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- req_ready = (state==IDLE) & RESET & ~flush. On accept, register funct3 and operands, and compute the path.
- Op mapping (mc_op, result):
  - MUL: 01, result1
  - MULH: 00, result2
  - MULHSU: 01, result2 − (op1[31] ? op2 : 0), mod 2^32
  - MULHU: 01, result2
  - DIV: 10, result1
  - DIVU: 11, result1
  - REM: 10, result2
  - REMU: 11, result2
- Special cases, resolved at accept; go IDLE→RESP directly with no mc_start:
  - op2==0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op1.
  - DIV with op1=0x80000000, op2=0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Cache (REUSE_EN=1):
  - Contents: tag {op1, op2, signed}, quotient, remainder, valid bit.
  - Fill: written on every normal-path divide that completes without flush.
  - Hit: divide-class request with a matching tag → IDLE→RESP, no mc_start.
  - Clear: RESET clears valid. Multiply and special cases neither read nor write the cache.
- Normal path: IDLE→ISSUE. ISSUE asserts mc_start with mc_op/mc_operand stable, then goes to WAIT.
- WAIT: stay while mc_busy=1. On the first cycle with mc_busy=0, capture the selected result (with MULHSU correction) into resp_data, write the cache if divide, then go to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- Flush:
  - In ISSUE or WAIT → DRAIN; MCycle cannot abort.
  - DRAIN waits for mc_busy=0, then IDLE with no response and no cache write.
  - In RESP, flush forces resp_valid=0.
  - In IDLE, flush blocks acceptance.
- mc_operand1/2 and mc_op hold their values from accept until the next accept.

## Timing
- Reset, while RESET=0 at a clock edge:
  - State: IDLE.
  - Outputs: resp_valid=0, resp_data=0, mc_start=0, mc_op=00, mc_operand1/2=0, busy=0, req_ready=0.
  - Cache: valid=0.
- Accept at edge T:
  - Special/hit: resp_valid in cycle T+1; req_ready again at T+2.
  - Normal: mc_start in T+1, WAIT from T+2. If mc_busy first reads 0 at cycle W, resp_valid is in W+1.
  - Normal total latency = MCycle compute cycles + 3.
- mc_start is never high outside ISSUE. It is never reissued while mc_busy=1.
- mc_busy=0 in the first WAIT cycle is treated as completion.
- Back-to-back: a new request can be accepted in the cycle after RESP.
- RESET low in any state aborts immediately to IDLE. mc_reset resets MCycle in the same cycle.

## Test plan
- MUL 7 × 0xFFFFFFFD → mc_op=01, resp_data=0xFFFFFFEB. MULH on the same operands → 0xFFFFFFFF.
- MULHSU op1=0xFFFFFFFF, op2=2 → unit returns result2=1; resp_data=0xFFFFFFFF.
- DIVU op2=0 → resp_valid at T+1 with 0xFFFFFFFF and no mc_start. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM on the same operands → 0.
- DIV 100/7 → 14 via MCycle. Then REM 100/7 → 2 at T+1 with no mc_start. Then REMU 100/7 → misses the cache and launches mc_op=11.
- Flush asserted in the second WAIT cycle of DIV → no resp_valid, busy held until mc_busy falls. A following DIV on the same operands misses the cache.
- RESET low during WAIT → all outputs at reset values next cycle. After release, MUL 3×5 → 15.
